// File: rtl/soc_system_master_secure_b2p_channel_filter.sv
// Channel filter for the master-secure return path: forwards packets on CHANNEL_ID, drops the rest.
// Optional dropped-packet counter is enabled by defining B2P_DROP_COUNT_EN.
module soc_system_master_secure_b2p_channel_filter #(
  parameter logic [7:0] CHANNEL_ID = 8'd0,
  parameter int         DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic [7:0]            in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t     state;
  state_t     state_next;
  logic       accept;
  logic       fwd;
  logic       err;
  logic       head_free;
  logic       full_next;
  logic       skid_valid;
  logic [7:0] skid_data;
  logic       skid_sop;
  logic       skid_eop;

  assign accept    = in_valid & in_ready;
  assign head_free = ~out_valid | out_ready;

  // A SOP always restarts classification as if in IDLE, flagging an error if a packet was open.
  always_comb begin
    fwd        = 1'b0;
    err        = 1'b0;
    state_next = state;
    if (accept) begin
      if (in_startofpacket || state == IDLE) begin
        if (!in_startofpacket) begin
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          err = (state != IDLE);
          if (in_channel == CHANNEL_ID) begin
            fwd        = 1'b1;
            state_next = in_endofpacket ? IDLE : PASS;
          end else begin
            state_next = in_endofpacket ? IDLE : DROP;
          end
        end
      end else if (state == PASS) begin
        fwd        = 1'b1;
        err        = (in_channel != CHANNEL_ID);
        state_next = in_endofpacket ? IDLE : PASS;
      end else begin
        state_next = in_endofpacket ? IDLE : DROP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      if (err) proto_err <= 1'b1;
    end
  end

  // Both slots occupied after this edge means the sink must be stalled next cycle.
  assign full_next = (~head_free & (skid_valid | fwd)) | (head_free & skid_valid & fwd);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= 8'd0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      skid_valid        <= 1'b0;
      skid_data         <= 8'd0;
      skid_sop          <= 1'b0;
      skid_eop          <= 1'b0;
    end else begin
      in_ready <= ~full_next;
      if (head_free) begin
        if (skid_valid) begin
          out_valid         <= 1'b1;
          out_data          <= skid_data;
          out_startofpacket <= skid_sop;
          out_endofpacket   <= skid_eop;
          skid_valid        <= fwd;
          if (fwd) begin
            skid_data <= in_data;
            skid_sop  <= in_startofpacket;
            skid_eop  <= in_endofpacket;
          end
        end else begin
          out_valid <= fwd;
          if (fwd) begin
            out_data          <= in_data;
            out_startofpacket <= in_startofpacket;
            out_endofpacket   <= in_endofpacket;
          end
        end
      end else if (fwd) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_sop   <= in_startofpacket;
        skid_eop   <= in_endofpacket;
      end
    end
  end

`ifdef B2P_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  drop_pkt;

  // Any accepted foreign-channel SOP starts a dropped packet, whatever the current state.
  assign drop_pkt = accept & in_startofpacket & (in_channel != CHANNEL_ID);

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_pkt && drop_cnt != {DROP_CNT_W{1'b1}}) begin
      drop_cnt <= drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_soc_system_master_secure_b2p_channel_filter.sv
// Bench for the b2p channel filter: table vectors, directed corner sequences and random
// packets checked against a packet-level reference model.
module tb_soc_system_master_secure_b2p_channel_filter;

  localparam logic [7:0] CH_ID   = 8'd0;
  localparam int         CW      = 4;
  localparam int         CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_ready;
  logic          in_valid;
  logic [7:0]    in_data;
  logic [7:0]    in_channel;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic          out_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [CW-1:0] drop_count;
  logic          proto_err;

  always #5 clk = ~clk;

  soc_system_master_secure_b2p_channel_filter #(
    .CHANNEL_ID(CH_ID),
    .DROP_CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_channel(in_channel),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .drop_count(drop_count),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic       v;
    logic [7:0] ch;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       ev;
    logic [7:0] ed;
    logic       esop;
    logic       eeop;
    logic       eerr;
  } vec_t;

  // Reference model: expected buffer contents plus the disposition of the open packet.
  beat_t exp_q[$];
  beat_t seen_q[$];
  int    disp;
  int    m_drops;
  bit    m_err;
  bit    m_block;
  bit    accepted;
  bit    tog;
  int    vectors = 0;
  int    misses  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drops(input int n);
`ifdef B2P_DROP_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput();
    cmp("in_ready", {31'd0, in_ready}, {31'd0, (!m_block && exp_q.size() < 2)});
    cmp("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0)});
    if (exp_q.size() > 0) begin
      cmp("out_data", {24'd0, out_data}, {24'd0, exp_q[0].data});
      cmp("out_sop", {31'd0, out_startofpacket}, {31'd0, exp_q[0].sop});
      cmp("out_eop", {31'd0, out_endofpacket}, {31'd0, exp_q[0].eop});
    end
    cmp("drop_count", {28'd0, drop_count}, exp_drops(m_drops));
    cmp("proto_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  task automatic model_beat();
    beat_t b;
    if (in_startofpacket) begin
      if (disp != 0) m_err = 1'b1;
      if (in_channel == CH_ID) begin
        disp = 1;
      end else begin
        disp = 2;
        if (m_drops < CNT_MAX) m_drops++;
      end
    end else if (disp == 0) begin
      m_err = 1'b1;
    end else if (disp == 1 && in_channel != CH_ID) begin
      m_err = 1'b1;
    end
    if (disp == 1) begin
      b.data = in_data;
      b.sop  = in_startofpacket;
      b.eop  = in_endofpacket;
      exp_q.push_back(b);
    end
    if (in_endofpacket) disp = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    disp    = 0;
    m_drops = 0;
    m_err   = 1'b0;
    m_block = 1'b1;
  endtask

  task automatic run_cycle();
    bit    acc;
    bit    emt;
    beat_t b;
    @(negedge clk);
    checkOutput();
    if (out_valid === 1'b1 && out_ready) begin
      b.data = out_data;
      b.sop  = out_startofpacket;
      b.eop  = out_endofpacket;
      seen_q.push_back(b);
    end
    acc = in_valid && !m_block && exp_q.size() < 2;
    emt = out_ready && exp_q.size() > 0;
    @(posedge clk);
    if (reset) begin
      model_reset();
      accepted = 1'b0;
    end else begin
      m_block = 1'b0;
      if (emt) void'(exp_q.pop_front());
      if (acc) model_beat();
      accepted = acc;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] ch, input logic [7:0] d,
                               input logic sop, input logic eop);
    in_valid         = v;
    in_channel       = ch;
    in_data          = d;
    in_startofpacket = sop;
    in_endofpacket   = eop;
  endtask

  task automatic set_ready(input int mode);
    if (mode == 0) begin
      out_ready = 1'b1;
    end else if (mode == 1) begin
      tog       = ~tog;
      out_ready = tog;
    end else begin
      out_ready = $urandom_range(0, 1);
    end
  endtask

  task automatic send_beat(input logic [7:0] ch, input logic [7:0] d, input logic sop,
                           input logic eop, input int mode);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, ch, d, sop, eop);
      set_ready(mode);
      run_cycle();
      if (accepted) begin
        in_valid = 1'b0;
        return;
      end
    end
    vectors++;
    misses++;
    $display("[TB] FAIL send_timeout: beat %0h never accepted, required within 40 cycles", d);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      set_ready(mode);
      run_cycle();
    end
  endtask

  task automatic drain(input int mode);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) return;
      idle(1, mode);
    end
    vectors++;
    misses++;
    $display("[TB] FAIL drain_timeout: %0d beats left, required 0", exp_q.size());
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 8'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'd3, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'd0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'd0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'd0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 8'd2, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    tog       = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    cmp("rst_in_ready", {31'd0, in_ready}, 32'd0);
    cmp("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_out_data", {24'd0, out_data}, 32'd0);
    cmp("rst_out_sop", {31'd0, out_startofpacket}, 32'd0);
    cmp("rst_out_eop", {31'd0, out_endofpacket}, 32'd0);
    cmp("rst_drop_count", {28'd0, drop_count}, 32'd0);
    cmp("rst_proto_err", {31'd0, proto_err}, 32'd0);
    idle(1, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].sop, tbl[i].eop);
      out_ready = 1'b1;
      run_cycle();
      cmp($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        cmp($sformatf("tbl%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].ed});
        cmp($sformatf("tbl%0d_sop", i), {31'd0, out_startofpacket}, {31'd0, tbl[i].esop});
        cmp($sformatf("tbl%0d_eop", i), {31'd0, out_endofpacket}, {31'd0, tbl[i].eeop});
      end
      cmp($sformatf("tbl%0d_err", i), {31'd0, proto_err}, {31'd0, tbl[i].eerr});
      idle(1, 0);
    end

    // Foreign 4-beat packet disappears entirely.
    do_reset();
    idle(1, 0);
    for (int i = 0; i < 4; i++) send_beat(8'd3, 8'(8'h40 + i), i == 0, i == 3, 0);
    idle(2, 0);
    cmp("t2_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("t2_in_ready", {31'd0, in_ready}, 32'd1);
    cmp("t2_drop_count", {28'd0, drop_count}, exp_drops(1));

    // 8-beat packet against a 1010 out_ready pattern.
    seen_q.delete();
    tog = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'd0, 8'(i), i == 0, i == 7, 1);
    drain(1);
    cmp("t3_count", seen_q.size(), 32'd8);
    for (int i = 0; i < seen_q.size() && i < 8; i++) begin
      cmp($sformatf("t3_data%0d", i), {24'd0, seen_q[i].data}, i);
      cmp($sformatf("t3_sop%0d", i), {31'd0, seen_q[i].sop}, {31'd0, i == 0});
      cmp($sformatf("t3_eop%0d", i), {31'd0, seen_q[i].eop}, {31'd0, i == 7});
    end

    // Stray beat in IDLE sets a sticky error.
    do_reset();
    idle(1, 0);
    send_beat(8'd0, 8'h12, 1'b0, 1'b1, 0);
    cmp("t4_err_set", {31'd0, proto_err}, 32'd1);
    send_beat(8'd0, 8'h21, 1'b1, 1'b0, 0);
    send_beat(8'd0, 8'h22, 1'b0, 1'b1, 0);
    send_beat(8'd0, 8'h23, 1'b1, 1'b1, 0);
    drain(0);
    idle(1, 0);
    cmp("t4_err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset in the middle of a forwarded packet.
    do_reset();
    idle(1, 0);
    send_beat(8'd2, 8'h01, 1'b1, 1'b1, 0);
    send_beat(8'd0, 8'h02, 1'b0, 1'b0, 0);
    send_beat(8'd0, 8'h50, 1'b1, 1'b0, 2);
    out_ready = 1'b0;
    send_beat(8'd0, 8'h51, 1'b0, 1'b0, 2);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    cmp("t5_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("t5_drop_count", {28'd0, drop_count}, 32'd0);
    cmp("t5_proto_err", {31'd0, proto_err}, 32'd0);
    cmp("t5_in_ready", {31'd0, in_ready}, 32'd0);
    idle(1, 0);
    seen_q.delete();
    for (int i = 0; i < 3; i++) send_beat(8'd0, 8'(8'h60 + i), i == 0, i == 2, 0);
    drain(0);
    cmp("t5_count", seen_q.size(), 32'd3);
    if (seen_q.size() > 0) begin
      cmp("t5_first_data", {24'd0, seen_q[0].data}, 32'h60);
      cmp("t5_first_sop", {31'd0, seen_q[0].sop}, 32'd1);
    end
    cmp("t5_err_clean", {31'd0, proto_err}, 32'd0);

    // Drop counter saturation.
    do_reset();
    idle(1, 0);
    for (int p = 0; p < 20; p++) begin
      send_beat(8'd1, 8'(p), 1'b1, 1'b0, 2);
      send_beat(8'd1, 8'(p + 1), 1'b0, 1'b1, 2);
    end
    idle(1, 0);
    cmp("t6_drop_sat", {28'd0, drop_count}, exp_drops(15));

    // Random traffic, including framing and channel errors.
    do_reset();
    idle(1, 0);
    for (int p = 0; p < 250; p++) begin
      int         len;
      logic [7:0] ch;
      len = $urandom_range(1, 5);
      ch  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : CH_ID;
      for (int j = 0; j < len; j++) begin
        logic       sop;
        logic [7:0] bch;
        sop = (j == 0);
        if ($urandom_range(0, 24) == 0) sop = ~sop;
        bch = ($urandom_range(0, 29) == 0) ? 8'd9 : ch;
        send_beat(bch, 8'($urandom), sop, j == len - 1, 2);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 2);
      end
    end
    drain(0);
    idle(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
